// File: rtl/usb_buffer_arbiter.sv
// usb_buffer_arbiter: single-port USB packet buffer shared by core
// and USB module, with ownership handoff and bounded starvation.
module usb_buffer_arbiter #(
  parameter int DEPTH_WORDS  = 256,
  parameter int ADDR_WIDTH   = $clog2(DEPTH_WORDS),
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk48,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [3:0]            core_wmask,
  input  logic [31:0]           core_wdata,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [31:0]           core_rdata,
  input  logic                  usb_req,
  input  logic [ADDR_WIDTH-1:0] usb_addr,
  input  logic [3:0]            usb_wmask,
  input  logic [31:0]           usb_wdata,
  output logic                  usb_gnt,
  output logic                  usb_rvalid,
  output logic [31:0]           usb_rdata,
  input  logic                  usb_done,
  input  logic [10:0]           usb_length,
  input  logic                  core_release,
  output logic                  core_owns,
  output logic [10:0]           data_length,
  output logic                  write_dropped
);

  localparam logic [7:0]  LIMIT   = 8'(STARVE_LIMIT);
  localparam logic [10:0] MAX_LEN = 11'(DEPTH_WORDS * 4);

  typedef enum logic {
    USB_OWNS  = 1'b0,
    CORE_OWNS = 1'b1
  } own_e;

  own_e        state_q, state_d;
  logic [10:0] len_q, len_d;
  logic        own_chg;
  logic [7:0]  starve_q, starve_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic                  owner_core;
  logic                  starved;
  logic                  core_pick;
  logic                  non_req;
  logic                  non_gnt;
  logic                  acc_wr;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [3:0]            acc_mask;
  logic [31:0]           acc_data;
  logic                  core_rv_q, usb_rv_q;
  logic                  drop_q;
  logic [31:0]           core_rd_q, usb_rd_q;

  always_ff @(posedge clk48) begin
    if (reset) begin
      state_q <= USB_OWNS;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    own_chg = 1'b0;
    unique case (state_q)
      USB_OWNS: begin
        if (usb_done) begin
          state_d = CORE_OWNS;
          own_chg = 1'b1;
          len_d   = (usb_length > MAX_LEN) ? MAX_LEN : usb_length;
        end
      end
      CORE_OWNS: begin
        if (core_release) begin
          state_d = USB_OWNS;
          own_chg = 1'b1;
        end
      end
      default: state_d = USB_OWNS;
    endcase
  end

  // Under contention the starved flag flips the default owner win.
  assign owner_core = (state_q == CORE_OWNS);
  assign starved    = (starve_q == LIMIT);
  assign core_pick  = core_req &
                      (~usb_req | (owner_core ^ starved));
  assign core_gnt   = ~reset & core_pick;
  assign usb_gnt    = ~reset & usb_req & ~core_pick;

  assign non_req  = owner_core ? usb_req : core_req;
  assign non_gnt  = owner_core ? usb_gnt : core_gnt;
  assign acc_addr = core_gnt ? core_addr  : usb_addr;
  assign acc_mask = core_gnt ? core_wmask : usb_wmask;
  assign acc_data = core_gnt ? core_wdata : usb_wdata;
  assign acc_wr   = (core_gnt | usb_gnt) & (|acc_mask);

  always_comb begin
    starve_d = '0;
    if (!own_chg && non_req && !non_gnt) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk48) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  always_ff @(posedge clk48) begin
    if (acc_wr && !non_gnt) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_mask[b]) mem[acc_addr][8*b +: 8] <= acc_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk48) begin
    if (reset) begin
      core_rv_q <= 1'b0;
      usb_rv_q  <= 1'b0;
      core_rd_q <= '0;
      usb_rd_q  <= '0;
      drop_q    <= 1'b0;
    end else begin
      core_rv_q <= core_gnt & ~(|core_wmask);
      usb_rv_q  <= usb_gnt & ~(|usb_wmask);
      drop_q    <= acc_wr & non_gnt;
      if (core_gnt && !(|core_wmask)) core_rd_q <= mem[core_addr];
      if (usb_gnt && !(|usb_wmask))   usb_rd_q  <= mem[usb_addr];
    end
  end

  // Responses still in flight when reset asserts are suppressed.
  assign core_rvalid   = core_rv_q & ~reset;
  assign usb_rvalid    = usb_rv_q & ~reset;
  assign write_dropped = drop_q & ~reset;
  assign core_rdata    = core_rd_q;
  assign usb_rdata     = usb_rd_q;
  assign core_owns     = owner_core;
  assign data_length   = len_q;

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// tb_usb_buffer_arbiter: directed and random traffic against a
// behavioural buffer model, read/drop responses via scoreboard.
module tb_usb_buffer_arbiter;

  localparam int AW    = 8;
  localparam int LIMIT = 8;
  localparam int MAXB  = 1024;

  logic          clk48 = 1'b0;
  logic          reset;
  logic          core_req, usb_req;
  logic [AW-1:0] core_addr, usb_addr;
  logic [3:0]    core_wmask, usb_wmask;
  logic [31:0]   core_wdata, usb_wdata;
  logic          core_gnt, usb_gnt;
  logic          core_rvalid, usb_rvalid;
  logic [31:0]   core_rdata, usb_rdata;
  logic          usb_done, core_release;
  logic [10:0]   usb_length;
  logic          core_owns;
  logic [10:0]   data_length;
  logic          write_dropped;

  usb_buffer_arbiter #(
    .DEPTH_WORDS(256), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk48(clk48), .reset(reset),
    .core_req(core_req), .core_addr(core_addr),
    .core_wmask(core_wmask), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .usb_req(usb_req), .usb_addr(usb_addr),
    .usb_wmask(usb_wmask), .usb_wdata(usb_wdata),
    .usb_gnt(usb_gnt), .usb_rvalid(usb_rvalid),
    .usb_rdata(usb_rdata),
    .usb_done(usb_done), .usb_length(usb_length),
    .core_release(core_release), .core_owns(core_owns),
    .data_length(data_length), .write_dropped(write_dropped)
  );

  always #5 clk48 = ~clk48;

  typedef struct {
    int          stamp;
    logic [31:0] data;
  } rd_t;

  rd_t cq[$];
  rd_t uq[$];
  int  dq[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk48) cyc <= cyc + 1;

  // Reference state: buffer image, who owns it, latched length,
  // and how many cycles in a row the non-owner has been refused.
  logic [31:0] mm [256];
  bit          m_core  = 1'b0;
  logic [10:0] m_len   = '0;
  int          m_denied = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic nxt();
    @(negedge clk48);
    reset        = 1'b0;
    core_req     = 1'b0;
    core_addr    = '0;
    core_wmask   = '0;
    core_wdata   = '0;
    usb_req      = 1'b0;
    usb_addr     = '0;
    usb_wmask    = '0;
    usb_wdata    = '0;
    usb_done     = 1'b0;
    usb_length   = '0;
    core_release = 1'b0;
  endtask

  task automatic access(bit is_core, logic [AW-1:0] a,
                        logic [3:0] m, logic [31:0] d,
                        bit is_owner);
    if (m == 4'd0) begin
      if (is_core) cq.push_back('{cyc + 1, mm[a]});
      else         uq.push_back('{cyc + 1, mm[a]});
    end else if (is_owner) begin
      for (int b = 0; b < 4; b++)
        if (m[b]) mm[a][8*b +: 8] = d[8*b +: 8];
    end else begin
      dq.push_back(cyc + 1);
    end
  endtask

  task automatic go();
    bit own_req, non_req, own_win, non_win;
    bit cg, ug, chg;
    #1;
    chk("core_owns", core_owns, m_core);
    chk("data_length", data_length, m_len);
    if (reset) begin
      chk("rst_core_gnt", core_gnt, 0);
      chk("rst_usb_gnt", usb_gnt, 0);
      while (cq.size() > 0 && cq[0].stamp == cyc) void'(cq.pop_front());
      while (uq.size() > 0 && uq[0].stamp == cyc) void'(uq.pop_front());
      while (dq.size() > 0 && dq[0] == cyc) void'(dq.pop_front());
      m_core   = 1'b0;
      m_len    = '0;
      m_denied = 0;
    end else begin
      own_req = m_core ? core_req : usb_req;
      non_req = m_core ? usb_req : core_req;
      own_win = own_req && !(non_req && m_denied == LIMIT);
      non_win = non_req && !own_win;
      cg = m_core ? own_win : non_win;
      ug = m_core ? non_win : own_win;
      chk("core_gnt", core_gnt, cg);
      chk("usb_gnt", usb_gnt, ug);
      if (cg) access(1'b1, core_addr, core_wmask, core_wdata, m_core);
      if (ug) access(1'b0, usb_addr, usb_wmask, usb_wdata, !m_core);
      chg = (!m_core && usb_done) || (m_core && core_release);
      if (chg)                     m_denied = 0;
      else if (non_req && !non_win) m_denied++;
      else                         m_denied = 0;
      if (!m_core && usb_done) begin
        m_core = 1'b1;
        m_len  = (usb_length > MAXB) ? 11'(MAXB) : usb_length;
      end else if (m_core && core_release) begin
        m_core = 1'b0;
      end
    end
  endtask

  initial begin : mon
    rd_t e;
    int  s;
    forever begin
      @(negedge clk48);
      #2;
      if (core_rvalid) begin
        if (cq.size() == 0) begin
          checks++; errors++;
          $display("FAIL core_rvalid_extra actual=1 expected=0 cycle=%0d", cyc);
        end else begin
          e = cq.pop_front();
          chk("core_rvalid_cycle", cyc, e.stamp);
          chk("core_rdata", core_rdata, e.data);
        end
      end
      if (usb_rvalid) begin
        if (uq.size() == 0) begin
          checks++; errors++;
          $display("FAIL usb_rvalid_extra actual=1 expected=0 cycle=%0d", cyc);
        end else begin
          e = uq.pop_front();
          chk("usb_rvalid_cycle", cyc, e.stamp);
          chk("usb_rdata", usb_rdata, e.data);
        end
      end
      if (write_dropped) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL write_dropped_extra actual=1 expected=0 cycle=%0d", cyc);
        end else begin
          s = dq.pop_front();
          chk("write_dropped_cycle", cyc, s);
        end
      end
    end
  end

  initial begin : drv
    int          ncg;
    bit          pc, pu;
    logic [AW-1:0] pca, pua;
    logic [3:0]  pcm, pum;
    logic [31:0] pcd, pud;

    reset = 1'b1;
    core_req = 1'b0; core_addr = '0; core_wmask = '0; core_wdata = '0;
    usb_req = 1'b0; usb_addr = '0; usb_wmask = '0; usb_wdata = '0;
    usb_done = 1'b0; usb_length = '0; core_release = 1'b0;

    nxt(); reset = 1'b1; go();
    nxt(); reset = 1'b1; go();
    nxt(); go();
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_usb_rdata", usb_rdata, 0);
    chk("rst_core_rvalid", core_rvalid, 0);
    chk("rst_drop", write_dropped, 0);

    nxt(); usb_req = 1; usb_addr = 3; usb_wmask = 4'hF;
    usb_wdata = 32'hDEADBEEF; go();
    nxt(); usb_done = 1; usb_length = 11'd64; go();
    nxt(); core_req = 1; core_addr = 3; go();
    chk("len_64", data_length, 64);
    chk("owns_after_done", core_owns, 1);

    nxt(); core_req = 1; core_addr = 3; core_wmask = 4'b0010;
    core_wdata = 32'h0000AB00; go();
    nxt(); core_req = 1; core_addr = 3; go();
    nxt(); usb_req = 1; usb_addr = 3; usb_wmask = 4'hF;
    usb_wdata = 32'h12345678; go();
    nxt(); core_req = 1; core_addr = 3; go();
    nxt(); go();
    chk("mm3_lane_write", mm[3], 32'hDEADABEF);

    nxt(); core_release = 1; go();
    ncg = 0;
    for (int i = 0; i < 20; i++) begin
      nxt(); core_req = 1; core_addr = 3; usb_req = 1; usb_addr = 3;
      go();
      ncg += int'(core_gnt);
    end
    chk("starve_core_grants", ncg, 2);

    nxt(); usb_done = 1; usb_length = 11'd2000; core_release = 1; go();
    nxt(); go();
    chk("len_clamp", data_length, MAXB);
    chk("both_in_usb", core_owns, 1);
    nxt(); usb_done = 1; usb_length = 11'd40; core_release = 1; go();
    nxt(); go();
    chk("both_in_core", core_owns, 0);
    chk("len_held", data_length, MAXB);

    nxt(); usb_done = 1; usb_length = 11'd64; go();
    nxt(); core_req = 1; core_addr = 3; go();
    nxt(); reset = 1; go();
    nxt(); go();
    chk("rst2_owns", core_owns, 0);
    chk("rst2_len", data_length, 0);
    chk("rst2_rvalid", core_rvalid, 0);
    nxt(); usb_req = 1; usb_addr = 3; go();
    nxt(); go();

    for (int a = 0; a < 16; a++) begin
      nxt(); usb_req = 1; usb_addr = AW'(a); usb_wmask = 4'hF;
      usb_wdata = $urandom; go();
    end

    pc = 0; pu = 0;
    pca = '0; pua = '0; pcm = '0; pum = '0; pcd = '0; pud = '0;
    for (int i = 0; i < 3000; i++) begin
      nxt();
      if (!pc && $urandom_range(0, 9) < 6) begin
        pc  = 1;
        pca = AW'($urandom_range(0, 15));
        pcm = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
        pcd = $urandom;
      end
      if (!pu && $urandom_range(0, 9) < 6) begin
        pu  = 1;
        pua = AW'($urandom_range(0, 15));
        pum = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
        pud = $urandom;
      end
      core_req = pc; core_addr = pca; core_wmask = pcm; core_wdata = pcd;
      usb_req = pu; usb_addr = pua; usb_wmask = pum; usb_wdata = pud;
      usb_done     = ($urandom_range(0, 11) == 0);
      usb_length   = 11'($urandom_range(0, 2047));
      core_release = ($urandom_range(0, 11) == 0);
      reset        = ($urandom_range(0, 149) == 0);
      go();
      if (core_gnt) pc = 0;
      if (usb_gnt)  pu = 0;
    end

    nxt(); go();
    nxt(); go();
    nxt(); go();
    chk("core_q_empty", cq.size(), 0);
    chk("usb_q_empty", uq.size(), 0);
    chk("drop_q_empty", dq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_buffer_arbiter.md
# usb_buffer_arbiter

Owns the USB packet buffer RAM and shares its single word port between the core and the USB module, both in the clk48 domain. Tracks buffer ownership: the USB module fills the buffer, hands it to the core with a length, and the core hands it back by releasing it. Arbitrates per cycle with priority to the current owner and a starvation bound for the non-owner. Discards writes from the non-owner.

## Interface
- DEPTH_WORDS, 256: buffer depth in 32-bit words (1024 bytes).
- ADDR_WIDTH, $clog2(DEPTH_WORDS): word address width.
- STARVE_LIMIT, 8: consecutive denied non-owner cycles before a forced non-owner grant; range 1–255.

- clk48  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high.
- core_req  input  1  core access request; held until granted.
- core_addr  input  ADDR_WIDTH  core word address.
- core_wmask  input  4  byte-lane write enables; 0 means read.
- core_wdata  input  32  core write data, lane-aligned.
- core_gnt  output  1  combinational; core access performed this cycle.
- core_rvalid  output  1  core read data valid.
- core_rdata  output  32  core read data.
- usb_req, usb_addr, usb_wmask, usb_wdata  input  1/ADDR_WIDTH/4/32  USB module request, same semantics as core_*.
- usb_gnt, usb_rvalid  output  1  same semantics as core_*.
- usb_rdata  output  32  same semantics as core_*.
- usb_done  input  1  pulse: packet complete, hand buffer to core.
- usb_length  input  11  byte count accompanying usb_done.
- core_release  input  1  pulse: core returns buffer to USB module.
- core_owns  output  1  1 = core owns the buffer (state CORE_OWNS).
- data_length  output  11  latched packet length in bytes.
- write_dropped  output  1  one-cycle pulse: a granted non-owner write was discarded.

## Operation
- Ownership FSM: USB_OWNS (reset state) and CORE_OWNS.
  - USB_OWNS, usb_done=1 -> CORE_OWNS; data_length <= min(usb_length, DEPTH_WORDS*4).
  - CORE_OWNS, core_release=1 -> USB_OWNS; data_length is held.
  - usb_done in CORE_OWNS and core_release in USB_OWNS are ignored. Both asserted in one cycle: only the one valid for the current state acts.
- Arbitration, one RAM access per cycle:
  - Only one requester: it is granted.
  - Both requesting: the owner is granted, unless starve_cnt == STARVE_LIMIT, in which case the non-owner is granted.
- starve_cnt, 8 bits:
  - Increments on each cycle the non-owner requests and is denied.
  - Clears when the non-owner is granted, when the non-owner is not requesting, or on an ownership change.
- Writes: a granted access with wmask≠0 writes the enabled byte lanes at addr.
  - Owner writes update the RAM.
  - Non-owner writes leave the RAM unchanged and pulse write_dropped.
  - Non-owner reads are performed normally.
- Granted reads with wmask=0 return mem[addr] to that requester. A granted write produces no rvalid.
- RAM contents are not cleared by reset.

## Timing
- gnt is combinational from req and registered state in the same cycle; the requester drops req or changes the request after the gnt edge.
- Read latency: 1 cycle. rvalid is high for exactly one cycle after a granted read, with rdata = RAM word before any write in that same edge (no write/read collision is possible: one access per cycle).
- rdata holds its last value while rvalid=0.
- An ownership change takes effect the cycle after the pulse. Arbitration and write discard in the pulse cycle use the old owner.
- write_dropped is registered and asserts the cycle after the discarded grant.
- Reset values: core_owns=0, data_length=0, all gnt=0 while reset=1, all rvalid=0, all rdata=0, write_dropped=0, starve_cnt=0.
- A grant in the cycle reset asserts has no effect. A read granted the cycle before reset produces no rvalid after reset.
- Address wrap: addresses ≥ DEPTH_WORDS are unreachable by construction (ADDR_WIDTH bits).

## Test plan
- Reset, USB writes 0xDEADBEEF at addr 3 with mask 4'b1111, then pulses usb_done with length 64. Core reads addr 3 -> core_owns=1 next cycle, data_length=64, core_rvalid one cycle after grant with rdata=0xDEADBEEF.
- In CORE_OWNS, core writes mask 4'b0010, data 0x0000AB00, at addr 3, then reads it -> 0xDEADABEF. USB write to addr 3 in CORE_OWNS -> write_dropped pulses, core re-read still 0xDEADABEF.
- Both requesters hold req continuously in USB_OWNS with STARVE_LIMIT=8 -> usb_gnt for 8 cycles, core_gnt on cycle 9, pattern repeats; starve_cnt returns to 0 after core grant.
- usb_done with usb_length=2000 -> data_length=1024. usb_done and core_release in the same cycle while in USB_OWNS -> CORE_OWNS. Repeated in CORE_OWNS -> USB_OWNS.
- Reset asserted the cycle after a granted core read in CORE_OWNS -> no core_rvalid, core_owns=0, data_length=0. RAM word retained on a subsequent read.
